// File: rtl/eth_rx_mac_filter_fifo.sv
// Store-and-forward RX buffer behind the RGMII MAC: filters frames on destination address and presents only complete good frames.
// Optional saturating drop/commit counters are enabled with `define ETH_RX_FILTER_STATS_EN.
module eth_rx_mac_filter_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [47:0] cfg_local_mac,
  input  logic        cfg_promisc,
  input  logic        cfg_bcast_en,
  input  logic        cfg_mcast_en,
  output logic        drop_bad,
  output logic        drop_filtered,
  output logic        drop_overflow,
`ifdef ETH_RX_FILTER_STATS_EN
  input  logic        stat_clear,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad,
  output logic [31:0] stat_filtered,
  output logic [31:0] stat_overflow,
`endif
  output logic        frame_good
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DROP} wst_e;

  wst_e            st_q;
  logic [2:0]      cnt_q;
  logic [47:0]     mac_q;
  logic            promisc_q, bcen_q, mcen_q, uc_q, bc_q, mc_q;
  logic [ADDR_W:0] wr_ptr_q, wr_cmt_q, rd_ptr_q;
  logic            bad_q, filt_q, ovf_q, good_q;
  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      rd_data_q;
  logic            s1_vld_q, out_vld_q, out_last_q;
  logic [7:0]      out_data_q;

  logic full, wr_en, uc_n, bc_n, accept_n, hdr_done;
  logic avail, out_rdy, rd_en;

  assign full     = (wr_ptr_q - rd_ptr_q) == (ADDR_W+1)'(DEPTH);
  assign wr_en    = s_axis_tvalid & (st_q != DROP) & ~full;
  assign uc_n     = uc_q & (s_axis_tdata == mac_q[47:40]);
  assign bc_n     = bc_q & (s_axis_tdata == 8'hFF);
  assign accept_n = promisc_q | uc_n | (bcen_q & bc_n) | (mcen_q & mc_q & ~bc_n);
  // Header is complete once six bytes are in and the address filter said yes.
  assign hdr_done = (st_q == BODY) | ((st_q == HDR) & (cnt_q == 3'd5) & accept_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      mac_q     <= '0;
      promisc_q <= 1'b0;
      bcen_q    <= 1'b0;
      mcen_q    <= 1'b0;
      uc_q      <= 1'b0;
      bc_q      <= 1'b0;
      mc_q      <= 1'b0;
      wr_ptr_q  <= '0;
      wr_cmt_q  <= '0;
      bad_q     <= 1'b0;
      filt_q    <= 1'b0;
      ovf_q     <= 1'b0;
      good_q    <= 1'b0;
    end else begin
      bad_q  <= 1'b0;
      filt_q <= 1'b0;
      ovf_q  <= 1'b0;
      good_q <= 1'b0;
      if (s_axis_tvalid) begin
        if (st_q == DROP) begin
          if (s_axis_tlast) st_q <= IDLE;
        end else if (full) begin
          wr_ptr_q <= wr_cmt_q;
          ovf_q    <= 1'b1;
          st_q     <= s_axis_tlast ? IDLE : DROP;
        end else if (s_axis_tlast) begin
          st_q <= IDLE;
          if (s_axis_tuser) begin
            wr_ptr_q <= wr_cmt_q;
            bad_q    <= 1'b1;
          end else if (!hdr_done) begin
            wr_ptr_q <= wr_cmt_q;
            filt_q   <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            wr_cmt_q <= wr_ptr_q + 1'b1;
            good_q   <= 1'b1;
          end
        end else begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          case (st_q)
            IDLE: begin
              promisc_q <= cfg_promisc;
              bcen_q    <= cfg_bcast_en;
              mcen_q    <= cfg_mcast_en;
              mac_q     <= {cfg_local_mac[39:0], 8'h00};
              uc_q      <= s_axis_tdata == cfg_local_mac[47:40];
              bc_q      <= s_axis_tdata == 8'hFF;
              mc_q      <= s_axis_tdata[0];
              cnt_q     <= 3'd1;
              st_q      <= HDR;
            end
            HDR: begin
              mac_q <= {mac_q[39:0], 8'h00};
              uc_q  <= uc_n;
              bc_q  <= bc_n;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd5) begin
                if (accept_n) begin
                  st_q <= BODY;
                end else begin
                  wr_ptr_q <= wr_cmt_q;
                  filt_q   <= 1'b1;
                  st_q     <= DROP;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};

  // The registered RAM word doubles as the skid slot: it only advances when the output slot frees up.
  assign avail   = rd_ptr_q != wr_cmt_q;
  assign out_rdy = ~out_vld_q | m_axis_tready;
  assign rd_en   = avail & (~s1_vld_q | out_rdy);

  always_ff @(posedge clk)
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rd_en)        s1_vld_q <= 1'b1;
      else if (out_rdy) s1_vld_q <= 1'b0;
      if (out_rdy) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) {out_last_q, out_data_q} <= rd_data_q;
      end
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign drop_bad      = bad_q;
  assign drop_filtered = filt_q;
  assign drop_overflow = ovf_q;
  assign frame_good    = good_q;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] st_good_q, st_bad_q, st_filt_q, st_ovf_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      st_good_q <= '0;
      st_bad_q  <= '0;
      st_filt_q <= '0;
      st_ovf_q  <= '0;
    end else begin
      if (good_q && st_good_q != '1) st_good_q <= st_good_q + 32'd1;
      if (bad_q  && st_bad_q  != '1) st_bad_q  <= st_bad_q  + 32'd1;
      if (filt_q && st_filt_q != '1) st_filt_q <= st_filt_q + 32'd1;
      if (ovf_q  && st_ovf_q  != '1) st_ovf_q  <= st_ovf_q  + 32'd1;
    end
  end

  assign stat_good     = st_good_q;
  assign stat_bad      = st_bad_q;
  assign stat_filtered = st_filt_q;
  assign stat_overflow = st_ovf_q;
`endif
endmodule

// File: tb/tb_eth_rx_mac_filter_fifo.sv
// Directed plus randomized bench for eth_rx_mac_filter_fifo, checked against a frame-level reference model.
module tb_eth_rx_mac_filter_fifo;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready;
  logic [47:0] cfg_local_mac = 48'h02_00_00_00_00_01;
  logic        cfg_promisc = 1'b0, cfg_bcast_en = 1'b0, cfg_mcast_en = 1'b0;
  logic        drop_bad, drop_filtered, drop_overflow, frame_good;

  eth_rx_mac_filter_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
    .cfg_mcast_en(cfg_mcast_en), .drop_bad(drop_bad), .drop_filtered(drop_filtered),
    .drop_overflow(drop_overflow), .frame_good(frame_good)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errs = 0;
  int rdy_mode = 0;  // 0: stalled, 1: always ready, 2: random
  logic [8:0] exp_q[$], obs_q[$];
  logic [7:0] frm[$];
  int n_good = 0, n_bad = 0, n_filt = 0, n_ovf = 0;
  int e_good = 0, e_bad = 0, e_filt = 0, e_ovf = 0;
  int viol = 0, rise_cyc = -1, filt_cyc = -1, b5_cyc = 0, last_cyc = 0;

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #2;
      m_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Output monitor: collects accepted beats, counts pulses, checks hold-under-stall.
  logic       hold_p = 1'b0, prev_v = 1'b0;
  logic [8:0] hold_w = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (hold_p && !(m_tvalid && {m_tlast, m_tdata} == hold_w)) viol++;
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
      hold_p = m_tvalid & ~m_tready;
      hold_w = {m_tlast, m_tdata};
      if (m_tvalid && !prev_v) rise_cyc = cyc;
      prev_v = m_tvalid;
      if (frame_good)    n_good++;
      if (drop_bad)      n_bad++;
      if (drop_overflow) n_ovf++;
      if (drop_filtered) begin n_filt++; filt_cyc = cyc; end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_good"}, n_good, e_good);
    chk({tag, "_bad"},  n_bad,  e_bad);
    chk({tag, "_filt"}, n_filt, e_filt);
    chk({tag, "_ovf"},  n_ovf,  e_ovf);
  endtask

  task automatic cmp_stream(input string tag);
    int bad = 0;
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    chk({tag, "_data"}, bad, 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic mk_frame(input logic [47:0] dest, input int len);
    frm.delete();
    for (int i = 0; i < len; i++)
      frm.push_back(i < 6 ? dest[47-8*i -: 8] : 8'($urandom));
  endtask

  function automatic bit accepts();
    logic [47:0] d = '0;
    for (int i = 0; i < 6; i++) d = {d[39:0], frm[i]};
    return cfg_promisc || d == cfg_local_mac || (cfg_bcast_en && d == '1) ||
           (cfg_mcast_en && frm[0][0] && d != '1);
  endfunction

  // With the output stalled, up to two committed bytes sit in the read pipeline and free their slots.
  function automatic bit fits_now(input int len);
    int pend = exp_q.size() - obs_q.size();
    int held = (pend < 2) ? pend : 2;
    return (len + pend - held) <= DEPTH;
  endfunction

  task automatic model(input bit tuser, input bit fits);
    int n = frm.size();
    if (!fits) e_ovf++;
    else if (n >= 6 && !accepts() && !(n == 6 && tuser)) e_filt++;
    else if (tuser) e_bad++;
    else if (n < 6) e_filt++;
    else begin
      e_good++;
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, frm[i]});
    end
  endtask

  task automatic send(input bit tuser, input int gapmax, input bit with_last);
    for (int i = 0; i < frm.size(); i++) begin
      if (gapmax > 0)
        repeat ($urandom_range(0, gapmax)) begin s_tvalid = 1'b0; @(posedge clk); #2; end
      s_tdata  = frm[i];
      s_tvalid = 1'b1;
      s_tlast  = with_last && (i == frm.size() - 1);
      s_tuser  = tuser && s_tlast;
      if (i == 5) b5_cyc = cyc;
      if (s_tlast) last_cyc = cyc;
      @(posedge clk); #2;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 6000 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [47:0] dest, input int len, input bit tuser);
    mk_frame(dest, len);
    model(tuser, fits_now(len));
    send(tuser, 0, 1);
  endtask

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  initial begin
    logic [47:0] dest;
    logic [31:0] r0, r1;
    logic [7:0]  saved[$];
    int len;
    bit tu;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata",  m_tdata, 0);
    chk("rst_tlast",  m_tlast, 0);
    chk("rst_pulses", {drop_bad, drop_filtered, drop_overflow, frame_good}, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // unicast hit, latency from input tlast to tvalid
    rdy_mode = 1;
    rise_cyc = -1;
    frame(LOCAL, 64, 0);
    drain();
    chk("uc_latency", rise_cyc, last_cyc + 3);
    cmp_stream("uc");
    chk_cnt("uc");

    // unicast miss, then promiscuous
    filt_cyc = -1;
    frame(OTHER, 64, 0);
    drain();
    chk("miss_filt_at_byte6", filt_cyc, b5_cyc + 1);
    cmp_stream("miss");
    chk_cnt("miss");
    cfg_promisc = 1'b1;
    frame(OTHER, 64, 0);
    drain();
    cmp_stream("promisc");
    chk_cnt("promisc");
    cfg_promisc = 1'b0;

    // broadcast off/on, multicast on
    frame(BCAST, 40, 0);
    cfg_bcast_en = 1'b1;
    frame(BCAST, 40, 0);
    cfg_mcast_en = 1'b1;
    frame(MCAST, 40, 0);
    drain();
    cmp_stream("bc_mc");
    chk_cnt("bc_mc");
    cfg_bcast_en = 1'b0;
    cfg_mcast_en = 1'b0;

    // good A, bad B, good C
    frame(LOCAL, 30, 0);
    frame(LOCAL, 30, 1);
    frame(LOCAL, 30, 0);
    drain();
    cmp_stream("abc");
    chk_cnt("abc");

    // runts: 1-byte and 5-byte frames
    frame(LOCAL, 1, 0);
    frame(LOCAL, 5, 0);
    frame(LOCAL, 6, 0);
    drain();
    cmp_stream("runt");
    chk_cnt("runt");

    // overflow: three 1000-byte frames with output stalled
    rdy_mode = 0;
    repeat (3) frame(LOCAL, 1000, 0);
    chk("ovf_count", n_ovf, 1);
    chk("ovf_committed", n_good, e_good);
    drain();
    cmp_stream("ovf_drain");
    chk_cnt("ovf");

    // oversized frame, then exactly-DEPTH and DEPTH+1 frames into an empty buffer
    rdy_mode = 0;
    frame(LOCAL, 3000, 0);
    drain();
    cmp_stream("big");
    rdy_mode = 0;
    frame(LOCAL, DEPTH, 0);
    drain();
    cmp_stream("exact");
    rdy_mode = 0;
    frame(LOCAL, DEPTH + 1, 0);
    drain();
    cmp_stream("exact_p1");
    chk_cnt("bound");

    // reset mid-frame; the remainder is seen as a new frame
    mk_frame(LOCAL, 64);
    saved = frm;
    frm = saved[0:29];
    send(0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("mid_rst_wr", dut.wr_ptr_q, 0);
    chk("mid_rst_cmt", dut.wr_cmt_q, 0);
    chk("mid_rst_rd", dut.rd_ptr_q, 0);
    chk("mid_rst_tvalid", m_tvalid, 0);
    frm = saved[30:63];
    model(0, 1);
    send(0, 0, 1);
    frame(LOCAL, 50, 0);
    drain();
    cmp_stream("mid_rst");
    chk_cnt("mid_rst");

    // randomized frames, random ready, random input gaps
    for (int b = 0; b < 4; b++) begin
      rdy_mode = 2;
      for (int f = 0; f < 10; f++) begin
        cfg_promisc  = ($urandom_range(0, 3) == 0);
        cfg_bcast_en = 1'($urandom_range(0, 1));
        cfg_mcast_en = 1'($urandom_range(0, 1));
        r0 = $urandom;
        r1 = $urandom;
        case ($urandom_range(0, 4))
          0: dest = LOCAL;
          1: dest = OTHER;
          2: dest = BCAST;
          3: dest = {24'h01005E, r0[23:0]};
          default: dest = {r0, r1[15:0]};
        endcase
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 100);
        tu = ($urandom_range(0, 5) == 0);
        mk_frame(dest, len);
        model(tu, fits_now(len));
        send(tu, 2, 1);
      end
      drain();
      cmp_stream("rnd");
      chk_cnt("rnd");
    end
    chk("hold_stable", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
